// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the registered, arbitrated bus multiplexer.
// Mode encodings and the select-width helper.
package mux_arbiter_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arbiter_bus_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts just after ptr and wraps, via a double-width request vector.
module rr_arbiter #(
  parameter int N       = 16,
  parameter int IdxBits = 4
) (
  input  logic [N-1:0]       req,
  input  logic [IdxBits-1:0] ptr,
  output logic               gntValid,
  output logic [IdxBits-1:0] gntIdx
);

  logic [2*N-1:0] dbl;

  assign dbl = {req, req};

  // Walk downward so the lowest eligible position wins.
  always_comb begin
    gntValid = 1'b0;
    gntIdx   = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (i > int'(ptr) && i <= int'(ptr) + N && dbl[i]) begin
        gntValid = 1'b1;
        gntIdx   = IdxBits'(i % N);
      end
    end
  end

endmodule

// File: rtl/mux_arbiter_bus.sv
// Registered N-way bus multiplexer with direct or round-robin selection.
// One-entry output register behind a valid/ready handshake.
module mux_arbiter_bus
  import mux_arbiter_pkg::*;
#(
  parameter int NrOfBits   = 32,
  parameter int NrOfInputs = 16,
  parameter int SelBits    = clog2(NrOfInputs)
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic                           Enable,
  input  logic                           Mode,
  input  logic [SelBits-1:0]             Sel,
  input  logic [NrOfInputs*NrOfBits-1:0] MuxIn,
  input  logic [NrOfInputs-1:0]          InValid,
  output logic [NrOfInputs-1:0]          InReady,
  output logic [NrOfBits-1:0]            MuxOut,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic [SelBits-1:0]             OutSel
);

  localparam int SelSpan = 2**SelBits;

  logic [SelBits-1:0]  rrPtr;
  logic [SelBits-1:0]  rrIdx;
  logic [SelBits-1:0]  gntIdx;
  logic                rrValid;
  logic                dirValid;
  logic                gntValid;
  logic                load;
  logic [SelSpan-1:0]  validPad;
  logic [NrOfBits-1:0] gntData;

  rr_arbiter #(
    .N       (NrOfInputs),
    .IdxBits (SelBits)
  ) uArb (
    .req      (InValid),
    .ptr      (rrPtr),
    .gntValid (rrValid),
    .gntIdx   (rrIdx)
  );

  // Padding lets any Sel index safely; out-of-range reads zero.
  assign validPad = SelSpan'(InValid);
  assign dirValid = (int'(Sel) < NrOfInputs) && validPad[Sel];

  assign gntValid = (Mode == MODE_RR) ? rrValid : dirValid;
  assign gntIdx   = (Mode == MODE_RR) ? rrIdx : Sel;

  assign load = Reset_n & Enable & gntValid
              & (~OutValid | OutReady);

  always_comb begin
    gntData = '0;
    InReady = '0;
    for (int k = 0; k < NrOfInputs; k++) begin
      if (gntIdx == SelBits'(k)) begin
        gntData    = MuxIn[k*NrOfBits +: NrOfBits];
        InReady[k] = load;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      OutValid <= 1'b0;
      MuxOut   <= '0;
      OutSel   <= '0;
      rrPtr    <= SelBits'(NrOfInputs - 1);
    end else begin
      if (load) begin
        OutValid <= 1'b1;
        MuxOut   <= gntData;
        OutSel   <= gntIdx;
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
      if (load && Mode == MODE_RR)
        rrPtr <= gntIdx;
    end
  end

endmodule

// File: tb/tb_mux_arbiter_bus.sv
// Directed bench for mux_arbiter_bus: vector table plus corner sequences.
// Channel k data is always seed + k.
module tb_mux_arbiter_bus;

  logic         Clock;
  logic         Reset_n;
  logic         Enable;
  logic         Mode;
  logic [3:0]   Sel;
  logic [511:0] MuxIn;
  logic [15:0]  InValid;
  logic [15:0]  InReady;
  logic [31:0]  MuxOut;
  logic         OutValid;
  logic         OutReady;
  logic [3:0]   OutSel;

  logic         Enable12;
  logic [3:0]   Sel12;
  logic [383:0] MuxIn12;
  logic [11:0]  InValid12;
  logic [11:0]  InReady12;
  logic [31:0]  MuxOut12;
  logic         OutValid12;
  logic         OutReady12;
  logic [3:0]   OutSel12;

  int nChecks = 0;
  int nFail   = 0;

  mux_arbiter_bus dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .Mode     (Mode),
    .Sel      (Sel),
    .MuxIn    (MuxIn),
    .InValid  (InValid),
    .InReady  (InReady),
    .MuxOut   (MuxOut),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutSel   (OutSel)
  );

  mux_arbiter_bus #(
    .NrOfBits   (32),
    .NrOfInputs (12),
    .SelBits    (4)
  ) dut12 (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Enable   (Enable12),
    .Mode     (1'b0),
    .Sel      (Sel12),
    .MuxIn    (MuxIn12),
    .InValid  (InValid12),
    .InReady  (InReady12),
    .MuxOut   (MuxOut12),
    .OutValid (OutValid12),
    .OutReady (OutReady12),
    .OutSel   (OutSel12)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        en;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] inV;
    logic        oRdy;
    logic [31:0] seed;
    logic [15:0] expRdy;
    logic        expValid;
    logic [3:0]  expSel;
    logic [31:0] expOut;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic en, input logic mode, input logic [3:0] sel,
    input logic [15:0] inV, input logic oRdy, input logic [31:0] seed,
    input logic [15:0] expRdy, input logic expValid,
    input logic [3:0] expSel, input logic [31:0] expOut);
    vec_t v;
    v.en = en; v.mode = mode; v.sel = sel; v.inV = inV;
    v.oRdy = oRdy; v.seed = seed; v.expRdy = expRdy;
    v.expValid = expValid; v.expSel = expSel; v.expOut = expOut;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setData(input logic [31:0] seed);
    for (int k = 0; k < 16; k++)
      MuxIn[k*32 +: 32] = seed + 32'(k);
  endtask

  task automatic setData12(input logic [31:0] seed);
    for (int k = 0; k < 12; k++)
      MuxIn12[k*32 +: 32] = seed + 32'(k);
  endtask

  task automatic step12(input logic [3:0] sel, input logic [11:0] expRdy,
                        input logic expValid, input logic [3:0] expSel,
                        input logic [31:0] expOut, input string tag);
    @(negedge Clock);
    Sel12 = sel;
    #1;
    check({tag, ".InReady12"}, 64'(InReady12), 64'(expRdy));
    @(posedge Clock);
    #1;
    check({tag, ".OutValid12"}, 64'(OutValid12), 64'(expValid));
    if (expValid) begin
      check({tag, ".OutSel12"}, 64'(OutSel12), 64'(expSel));
      check({tag, ".MuxOut12"}, 64'(MuxOut12), 64'(expOut));
    end
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; Mode = 1'b0; Sel = '0;
    MuxIn = '0; InValid = '0; OutReady = 1'b0;
    Enable12 = 1'b0; Sel12 = '0; MuxIn12 = '0;
    InValid12 = '0; OutReady12 = 1'b0;

    // Stimulus table
    vecs.push_back(mk(1, 0, 5, 16'h0000, 1, 32'h0, 16'h0000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 5, 16'h0020, 1, 32'hDEADBEEA,
                      16'h0020, 1, 5, 32'hDEADBEEF));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 5, 16'h0020, 0, 32'h11111110,
                        16'h0000, 1, 5, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 5, 16'h0020, 1, 32'h11111110,
                      16'h0020, 1, 5, 32'h11111115));
    vecs.push_back(mk(1, 0, 5, 16'h0000, 1, 32'h0,
                      16'h0000, 0, 5, 32'h11111115));
    for (int i = 0; i < 18; i++)
      vecs.push_back(mk(1, 1, 0, 16'hFFFF, 1, 32'hA0000000,
                        16'(1 << (i % 16)), 1, 4'(i % 16),
                        32'hA0000000 + 32'(i % 16)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, 0, 16'h0009, 1, 32'hB0000000,
                        (i % 2 == 0) ? 16'h0008 : 16'h0001, 1,
                        (i % 2 == 0) ? 4'd3 : 4'd0,
                        (i % 2 == 0) ? 32'hB0000003 : 32'hB0000000));
    vecs.push_back(mk(0, 1, 0, 16'hFFFF, 0, 32'hE0000000,
                      16'h0000, 1, 0, 32'hB0000000));
    vecs.push_back(mk(0, 1, 0, 16'hFFFF, 1, 32'hE0000000,
                      16'h0000, 0, 0, 32'hB0000000));
    vecs.push_back(mk(0, 1, 0, 16'hFFFF, 1, 32'hE0000000,
                      16'h0000, 0, 0, 32'hB0000000));
    vecs.push_back(mk(1, 0, 2, 16'h0004, 1, 32'hC0000000,
                      16'h0004, 1, 2, 32'hC0000002));
    vecs.push_back(mk(1, 1, 0, 16'hFFFF, 1, 32'hD0000000,
                      16'h0002, 1, 1, 32'hD0000001));

    // Reset state
    #12;
    check("rst.OutValid", 64'(OutValid), 64'(0));
    check("rst.MuxOut", 64'(MuxOut), 64'(0));
    check("rst.OutSel", 64'(OutSel), 64'(0));
    check("rst.InReady", 64'(InReady), 64'(0));
    @(negedge Clock);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge Clock);
      Enable = vecs[i].en; Mode = vecs[i].mode; Sel = vecs[i].sel;
      InValid = vecs[i].inV; OutReady = vecs[i].oRdy;
      setData(vecs[i].seed);
      #1;
      check($sformatf("v%0d.InReady", i), 64'(InReady),
            64'(vecs[i].expRdy));
      @(posedge Clock);
      #1;
      check($sformatf("v%0d.OutValid", i), 64'(OutValid),
            64'(vecs[i].expValid));
      check($sformatf("v%0d.OutSel", i), 64'(OutSel),
            64'(vecs[i].expSel));
      check($sformatf("v%0d.MuxOut", i), 64'(MuxOut),
            64'(vecs[i].expOut));
    end

    // Twelve-channel instance: out-of-range selects grant nothing
    @(negedge Clock);
    Enable = 1'b0; InValid = '0;
    Enable12 = 1'b1; InValid12 = 12'hFFF; OutReady12 = 1'b1;
    setData12(32'h55550000);
    step12(4'd15, 12'h000, 0, 0, 32'h0, "sel15");
    step12(4'd12, 12'h000, 0, 0, 32'h0, "sel12");
    step12(4'd11, 12'h800, 1, 4'd11, 32'h5555000B, "sel11");
    Enable12 = 1'b0;

    // Asynchronous reset in the middle of a stall
    @(negedge Clock);
    Enable = 1'b1; Mode = 1'b0; Sel = 4'd5;
    InValid = 16'h0020; OutReady = 1'b1;
    setData(32'h12340000);
    @(posedge Clock);
    #1;
    check("ar.loaded", 64'(MuxOut), 64'h12340005);
    @(negedge Clock);
    OutReady = 1'b0;
    @(posedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    check("ar.OutValid", 64'(OutValid), 64'(0));
    check("ar.MuxOut", 64'(MuxOut), 64'(0));
    check("ar.OutSel", 64'(OutSel), 64'(0));
    @(negedge Clock);
    Reset_n = 1'b1;
    Mode = 1'b1; InValid = 16'hFFFF; OutReady = 1'b1;
    setData(32'h77770000);
    #1;
    check("ar.rrInReady", 64'(InReady), 64'h0001);
    @(posedge Clock);
    #1;
    check("ar.rrOutSel", 64'(OutSel), 64'(0));
    check("ar.rrMuxOut", 64'(MuxOut), 64'h77770000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
